// File: rtl/nvr_pkg.sv
// nvr_pkg: shared encodings for the NVR load sequencer and the WVR/SVR register banks.
package nvr_pkg;

    localparam int unsigned DATA_W   = 512;
    localparam int unsigned MODE_W   = 3;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned BANK_A_W = MODE_W + IDX_W;

    localparam logic [MODE_W-1:0]   MODE_SINGLE = 3'b000;
    localparam logic [MODE_W-1:0]   MODE_QUAD   = 3'b001;
    localparam logic [MODE_W-1:0]   MODE_FULL   = 3'b010;
    localparam logic [IDX_W-1:0]    IDX_MAX     = 5'd15;
    localparam logic [BANK_A_W-1:0] BANK_NOP_A  = 8'hE0;

    localparam logic TGT_WVR = 1'b0;
    localparam logic TGT_SVR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Full loads ignore the index; single/quad need an index inside the 16-entry bank.
    function automatic logic cmd_legal(input logic [MODE_W-1:0] mode, input logic [IDX_W-1:0] idx);
        return (mode == MODE_FULL) ||
               (((mode == MODE_SINGLE) || (mode == MODE_QUAD)) && (idx <= IDX_MAX));
    endfunction

endpackage

// File: rtl/nvr_load_sequencer.sv
// nvr_load_sequencer: accepts one load command, issues one 512-bit memory read and
// drives a single write cycle onto the selected bank; bank ports otherwise sit at NOP.
module nvr_load_sequencer
    import nvr_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_target,
    input  logic [MODE_W-1:0]   cmd_mode,
    input  logic [IDX_W-1:0]    cmd_idx,
    input  logic [ADDR_W-1:0]   cmd_addr,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic [BANK_A_W-1:0] wvr_a,
    output logic [DATA_W-1:0]   wvr_d,
    output logic [BANK_A_W-1:0] svr_a,
    output logic [DATA_W-1:0]   svr_d,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state, state_nx;
    logic                tgt_q, tgt_nx;
    logic [MODE_W-1:0]   mode_q, mode_nx;
    logic [IDX_W-1:0]    idx_q, idx_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [DATA_W-1:0]   buf_q, buf_nx;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic                req_nx, done_nx, err_nx;
    logic [BANK_A_W-1:0] wvr_a_nx, svr_a_nx;
    logic [DATA_W-1:0]   wvr_d_nx, svr_d_nx;

    assign cmd_ready = (state == ST_IDLE);

    // Next state plus next value of every registered output.
    always_comb begin
        state_nx = state;
        tgt_nx   = tgt_q;
        mode_nx  = mode_q;
        idx_nx   = idx_q;
        addr_nx  = mem_req_addr;
        buf_nx   = buf_q;
        cnt_nx   = cnt_q;
        req_nx   = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        wvr_a_nx = BANK_NOP_A;
        wvr_d_nx = '0;
        svr_a_nx = BANK_NOP_A;
        svr_d_nx = '0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_nx  = cmd_target;
                    mode_nx = cmd_mode;
                    idx_nx  = (cmd_mode == MODE_FULL) ? '0 : cmd_idx;
                    addr_nx = cmd_addr;
                    if (cmd_legal(cmd_mode, cmd_idx)) begin
                        state_nx = ST_REQ;
                        req_nx   = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = '0;
                end else begin
                    req_nx = 1'b1;
                end
            end
            ST_WAIT: begin
                // A response in the expiry cycle still wins over the timeout.
                if (mem_rsp_valid) begin
                    buf_nx   = mem_rsp_data;
                    state_nx = ST_WRITE;
                    if (tgt_q == TGT_WVR) begin
                        wvr_a_nx = {mode_q, idx_q};
                        wvr_d_nx = buf_nx;
                    end else begin
                        svr_a_nx = {mode_q, idx_q};
                        svr_d_nx = buf_nx;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                done_nx  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            tgt_q         <= 1'b0;
            mode_q        <= '0;
            idx_q         <= '0;
            mem_req_addr  <= '0;
            buf_q         <= '0;
            cnt_q         <= '0;
            mem_req_valid <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            wvr_a         <= BANK_NOP_A;
            wvr_d         <= '0;
            svr_a         <= BANK_NOP_A;
            svr_d         <= '0;
        end else begin
            state         <= state_nx;
            tgt_q         <= tgt_nx;
            mode_q        <= mode_nx;
            idx_q         <= idx_nx;
            mem_req_addr  <= addr_nx;
            buf_q         <= buf_nx;
            cnt_q         <= cnt_nx;
            mem_req_valid <= req_nx;
            done          <= done_nx;
            err           <= err_nx;
            busy          <= (state_nx != ST_IDLE);
            wvr_a         <= wvr_a_nx;
            wvr_d         <= wvr_d_nx;
            svr_a         <= svr_a_nx;
            svr_d         <= svr_d_nx;
        end
    end

endmodule

// File: tb/tb_nvr_load_sequencer.sv
// tb_nvr_load_sequencer: table-driven and randomized load commands checked against a
// latency/legality model and a behavioural model of the two 16 x 32-bit banks.
module tb_nvr_load_sequencer;
    import nvr_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TMO    = 8;
    localparam int          NRAND  = 40;

    typedef logic [15:0][31:0] bank_t;

    typedef struct {
        logic        target;
        logic [2:0]  mode;
        logic [4:0]  idx;
        logic [31:0] addr;
        int          req_wait;
        int          rsp_wait;
        logic [511:0] data;
        logic        exp_done;
        logic        exp_err;
        int          exp_t;      // cycles from accept edge to the done/err pulse
        logic [7:0]  exp_a;
        int          chk_reg;    // bank register to spot-check, -1 for none
        logic [31:0] chk_val;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid, cmd_ready, cmd_target;
    logic [2:0]         cmd_mode;
    logic [4:0]         cmd_idx;
    logic [ADDR_W-1:0]  cmd_addr;
    logic               mem_req_valid, mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_rsp_valid;
    logic [511:0]       mem_rsp_data;
    logic [7:0]         wvr_a, svr_a;
    logic [511:0]       wvr_d, svr_d;
    logic               busy, done, err;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bank_t exp_bank [2];
    bank_t obs_bank [2];
    vec_t  tbl [8];

    nvr_load_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_mode(cmd_mode), .cmd_idx(cmd_idx), .cmd_addr(cmd_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wvr_a(wvr_a), .wvr_d(wvr_d), .svr_a(svr_a), .svr_d(svr_d),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; returns at the following falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Bank semantics: single writes one word, quad four words with wrap, full all sixteen.
    function automatic bank_t bank_apply(input bank_t cur, input logic [2:0] mode,
                                         input logic [4:0] idx, input logic [511:0] d);
        bank_t r;
        r = cur;
        case (mode)
            3'd0: r[idx[3:0]] = d[31:0];
            3'd1: for (int k = 0; k < 4; k++) r[(int'(idx) + k) % 16] = d[32*k +: 32];
            3'd2: for (int k = 0; k < 16; k++) r[k] = d[32*k +: 32];
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [511:0] mk4(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
        logic [511:0] d;
        d = '0;
        d[31:0] = w0; d[63:32] = w1; d[95:64] = w2; d[127:96] = w3;
        return d;
    endfunction

    function automatic vec_t tv(input logic tgt, input logic [2:0] mode, input logic [4:0] idx,
                                input logic [31:0] addr, input int rw, input int sw,
                                input logic [511:0] data, input logic edone, input logic eerr,
                                input int et, input logic [7:0] ea, input int creg,
                                input logic [31:0] cval);
        vec_t v;
        v.target = tgt; v.mode = mode; v.idx = idx; v.addr = addr;
        v.req_wait = rw; v.rsp_wait = sw; v.data = data;
        v.exp_done = edone; v.exp_err = eerr; v.exp_t = et; v.exp_a = ea;
        v.chk_reg = creg; v.chk_val = cval;
        return v;
    endfunction

    // Expected outcome from the command rules: legality, timeout budget and fixed latency.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic legal;
        r = v;
        legal = (v.mode == 3'd2) || ((v.mode <= 3'd1) && (v.idx <= 5'd15));
        r.exp_a = {v.mode, (v.mode == 3'd2) ? 5'd0 : v.idx};
        r.chk_reg = -1;
        r.chk_val = '0;
        if (!legal) begin
            r.exp_done = 1'b0; r.exp_err = 1'b1; r.exp_t = 1;
        end else if (v.rsp_wait >= int'(TMO)) begin
            r.exp_done = 1'b0; r.exp_err = 1'b1; r.exp_t = 2 + v.req_wait + int'(TMO);
        end else begin
            r.exp_done = 1'b1; r.exp_err = 1'b0; r.exp_t = 4 + v.req_wait + v.rsp_wait;
        end
        return r;
    endfunction

    task automatic run_cmd(input vec_t v, input string tag);
        int acc;
        int done_n = 0, done_t = -1, err_n = 0, err_t = -1, busy_n = 0;
        int req_n = 0, addr_bad = 0, nop_bad = 0, rb_bad = 0;
        int wr_n [2] = '{0, 0};
        int wr_t = -1;
        logic [7:0]   wr_a = BANK_NOP_A;
        logic [511:0] wr_d = '0;
        int req_seen = 0, rsp_cnt = -1;
        bit hs = 0;
        int sel, oth, exp_req, budget;

        sel = int'(v.target);
        oth = 1 - sel;
        cmd_valid = 1'b1; cmd_target = v.target; cmd_mode = v.mode;
        cmd_idx = v.idx; cmd_addr = v.addr;
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
        cmd_target = 1'($urandom); cmd_mode = 3'($urandom);
        cmd_idx = 5'($urandom); cmd_addr = $urandom;

        budget = 12 + v.req_wait + v.rsp_wait + int'(TMO);
        for (int c = 0; c < budget; c++) begin
            // a pulse registered at edge N is seen by consumers at edge N+1
            if (done) begin done_n++; if (done_t < 0) done_t = cyc + 1 - acc; end
            if (err)  begin err_n++;  if (err_t < 0)  err_t  = cyc + 1 - acc; end
            if (busy) busy_n++;
            if (cmd_ready !== !busy) rb_bad++;
            if (wvr_a != BANK_NOP_A) begin
                wr_n[0]++; wr_t = cyc + 1 - acc; wr_a = wvr_a; wr_d = wvr_d;
                obs_bank[0] = bank_apply(obs_bank[0], wvr_a[7:5], wvr_a[4:0], wvr_d);
            end else if (wvr_d != '0) nop_bad++;
            if (svr_a != BANK_NOP_A) begin
                wr_n[1]++; wr_t = cyc + 1 - acc; wr_a = svr_a; wr_d = svr_d;
                obs_bank[1] = bank_apply(obs_bank[1], svr_a[7:5], svr_a[4:0], svr_d);
            end else if (svr_d != '0) nop_bad++;
            if (mem_req_valid) begin
                req_n++;
                if (mem_req_addr !== v.addr) addr_bad++;
            end

            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = ~v.data;
            if (rsp_cnt >= 0) begin
                if (rsp_cnt == v.rsp_wait) begin
                    mem_rsp_valid = 1'b1; mem_rsp_data = v.data;
                end
                rsp_cnt++;
            end
            if (mem_req_valid && !hs) begin
                mem_req_ready = (req_seen >= v.req_wait);
                req_seen++;
                if (mem_req_ready) begin hs = 1; rsp_cnt = 0; end
            end
            tick();
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;

        exp_req = (v.exp_err && v.exp_t == 1) ? 0 : v.req_wait + 1;
        check({tag, ".done_cnt"}, done_n, v.exp_done ? 1 : 0);
        check({tag, ".err_cnt"}, err_n, v.exp_err ? 1 : 0);
        if (v.exp_done) check({tag, ".done_at"}, done_t, v.exp_t);
        if (v.exp_err)  check({tag, ".err_at"}, err_t, v.exp_t);
        check({tag, ".busy_cycles"}, busy_n, v.exp_t - 1);
        check({tag, ".sel_writes"}, wr_n[sel], v.exp_done ? 1 : 0);
        check({tag, ".other_writes"}, wr_n[oth], 0);
        if (v.exp_done) begin
            check({tag, ".wr_a"}, wr_a, v.exp_a);
            check({tag, ".wr_d"}, wr_d, v.data);
            check({tag, ".wr_at"}, wr_t, v.exp_t - 1);
            exp_bank[sel] = bank_apply(exp_bank[sel], v.exp_a[7:5], v.exp_a[4:0], v.data);
        end
        check({tag, ".nop_d"}, nop_bad, 0);
        check({tag, ".req_cycles"}, req_n, exp_req);
        check({tag, ".req_addr"}, addr_bad, 0);
        check({tag, ".ready_busy"}, rb_bad, 0);
        check({tag, ".bank_wvr"}, obs_bank[0], exp_bank[0]);
        check({tag, ".bank_svr"}, obs_bank[1], exp_bank[1]);
        if (v.chk_reg >= 0) check({tag, ".reg"}, obs_bank[sel][v.chk_reg], v.chk_val);
    endtask

    initial begin
        logic [511:0] full_d;
        vec_t v;
        int n_done, n_err, n_wr, n_busy;

        full_d = '0;
        for (int k = 0; k < 16; k++) full_d[32*k +: 32] = 32'(k);
        exp_bank[0] = '0; exp_bank[1] = '0;
        obs_bank[0] = '0; obs_bank[1] = '0;

        //            tgt  mode  idx    addr      rw sw data                          done err t   a      reg  val
        tbl[0] = tv(1'b0, 3'd0, 5'd5,  32'h100, 0, 0,  mk4(32'hDEADBEEF, 1, 2, 3),   1, 0, 4,  8'h05, 5,  32'hDEADBEEF);
        tbl[1] = tv(1'b1, 3'd1, 5'd14, 32'h200, 3, 0,  mk4(32'h11, 32'h22, 32'h33, 32'h44), 1, 0, 7, 8'h2E, 0, 32'h33);
        tbl[2] = tv(1'b0, 3'd2, 5'd9,  32'h300, 0, 0,  full_d,                       1, 0, 4,  8'h40, 15, 32'd15);
        tbl[3] = tv(1'b0, 3'd3, 5'd2,  32'h340, 0, 0,  mk4(7, 7, 7, 7),              0, 1, 1,  8'hE0, -1, 0);
        tbl[4] = tv(1'b1, 3'd0, 5'd16, 32'h380, 0, 0,  mk4(8, 8, 8, 8),              0, 1, 1,  8'hE0, -1, 0);
        tbl[5] = tv(1'b1, 3'd0, 5'd1,  32'h3C0, 0, 10, mk4(32'hBAD0, 0, 0, 0),       0, 1, 10, 8'h01, -1, 0);
        tbl[6] = tv(1'b0, 3'd0, 5'd7,  32'h400, 0, 7,  mk4(32'hCAFE0007, 0, 0, 0),   1, 0, 11, 8'h07, 7,  32'hCAFE0007);
        tbl[7] = tv(1'b0, 3'd1, 5'd13, 32'h440, 1, 2,  mk4(32'hA1, 32'hB2, 32'hC3, 32'hD4), 1, 0, 7, 8'h2D, 0, 32'hD4);

        reset = 1'b1; cmd_valid = 1'b0; cmd_target = 1'b0; cmd_mode = '0; cmd_idx = '0;
        cmd_addr = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick(); tick();
        check("rst.wvr_a", wvr_a, 8'hE0);
        check("rst.svr_a", svr_a, 8'hE0);
        check("rst.wvr_d", wvr_d, '0);
        check("rst.svr_d", svr_d, '0);
        check("rst.req_valid", mem_req_valid, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.err", err, 1'b0);
        check("rst.cmd_ready", cmd_ready, 1'b1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for the response: nothing may be written afterwards.
        cmd_valid = 1'b1; cmd_target = 1'b0; cmd_mode = 3'd0; cmd_idx = 5'd3; cmd_addr = 32'h500;
        tick();
        cmd_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        check("mid.busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("mid.wvr_a", wvr_a, 8'hE0);
        check("mid.svr_a", svr_a, 8'hE0);
        check("mid.wvr_d", wvr_d, '0);
        check("mid.req_valid", mem_req_valid, 1'b0);
        check("mid.busy", busy, 1'b0);
        check("mid.cmd_ready", cmd_ready, 1'b1);
        tick();
        reset = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = mk4(32'hFEEDFACE, 1, 1, 1);
        n_done = 0; n_err = 0; n_wr = 0; n_busy = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            mem_rsp_valid = 1'b0;
            if (done) n_done++;
            if (err) n_err++;
            if (busy) n_busy++;
            if (wvr_a != BANK_NOP_A || svr_a != BANK_NOP_A) n_wr++;
        end
        check("mid.no_done", n_done, 0);
        check("mid.no_err", n_err, 0);
        check("mid.no_write", n_wr, 0);
        check("mid.no_busy", n_busy, 0);
        v = model(tv(TGT_SVR, 3'd0, 5'd3, 32'h540, 1, 1, mk4(32'h600D, 0, 0, 0), 0, 0, 0, 0, -1, 0));
        run_cmd(v, "after_rst");

        for (int i = 0; i < NRAND; i++) begin
            int r;
            v.target = 1'($urandom);
            r = int'($urandom_range(0, 9));
            v.mode = (r < 7) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            v.idx = 5'($urandom_range(0, (v.mode == 3'd2) ? 31 : 19));
            v.addr = $urandom;
            v.req_wait = int'($urandom_range(0, 3));
            v.rsp_wait = int'($urandom_range(0, 10));
            for (int k = 0; k < 16; k++) v.data[32*k +: 32] = $urandom;
            run_cmd(model(v), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
